// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential unsigned shift-and-add multiplier controller.
// Drives an external N-bit combinational adder with {A, Q[0] ? M : 0} once per
// multiplier bit and shifts the adder result (carry included) back into {A,Q}.
// After N passes the 2N-bit product is latched and a one-cycle done is raised.
module shift_add_mult_ctrl #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    input  logic [N-1:0]   add_sum,
    input  logic           add_cout
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    logic             last_pass;
    assign last_pass = (cnt_q == LAST_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE waits for start, RUN lasts N passes, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_pass) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers; reset discards any in-flight operation and the product
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Datapath update: operand capture in IDLE, one shift-add pass per RUN cycle
    always_comb begin
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d   = multiplicand;
                    q_d   = multiplier;
                    a_d   = '0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                // Carry-out becomes the accumulator MSB, so nothing is lost
                a_d   = {add_cout, add_sum[N-1:1]};
                q_d   = {add_sum[0], q_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_pass) begin
                    product_d = {add_cout, add_sum, q_q[N-1:1]};
                end
            end
            default: ;
        endcase
    end

    // Outputs: adder operands are only non-zero while running
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        add_a = '0;
        add_b = '0;
        case (state_q)
            RUN: begin
                busy  = 1'b1;
                add_a = a_q;
                add_b = q_q[0] ? m_q : '0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Testbench for shift_add_mult_ctrl: an 8-bit and a 64-bit instance, each
// wired to its own behavioural ripple-carry adder.
module tb_shift_add_mult_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;

    // 8-bit instance
    logic         start8;
    logic [7:0]   mc8, mp8;
    logic         busy8, done8;
    logic [15:0]  product8;
    logic [7:0]   add_a8, add_b8, add_sum8;
    logic         add_cout8;
    assign {add_cout8, add_sum8} = {1'b0, add_a8} + {1'b0, add_b8};

    // 64-bit instance
    logic         start64;
    logic [63:0]  mc64, mp64;
    logic         busy64, done64;
    logic [127:0] product64;
    logic [63:0]  add_a64, add_b64, add_sum64;
    logic         add_cout64;
    assign {add_cout64, add_sum64} = {1'b0, add_a64} + {1'b0, add_b64};

    shift_add_mult_ctrl #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(start8),
        .multiplicand(mc8), .multiplier(mp8),
        .busy(busy8), .done(done8), .product(product8),
        .add_a(add_a8), .add_b(add_b8),
        .add_sum(add_sum8), .add_cout(add_cout8)
    );

    shift_add_mult_ctrl #(.N(64)) u64 (
        .clk(clk), .rst(rst), .start(start64),
        .multiplicand(mc64), .multiplier(mp64),
        .busy(busy64), .done(done64), .product(product64),
        .add_a(add_a64), .add_b(add_b64),
        .add_sum(add_sum64), .add_cout(add_cout64)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] prev8 = '0;

    // One 8-bit multiplication with per-cycle checks of done, busy, adder
    // operands and product stability; returns at the falling edge in DONE.
    task automatic run8(input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] expv, input string tag);
        logic [7:0] am, aa, aq, eb;
        logic [8:0] s;
        @(negedge clk);
        mc8 = m; mp8 = q; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0; mc8 = ~m; mp8 = ~q;
        am = m; aa = '0; aq = q;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (done8 !== ((k == 9) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b want %b", tag, k, done8, (k == 9));
            end
            checks++;
            if (busy8 !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want 1", tag, k, busy8);
            end
            if (k <= 8) begin
                eb = aq[0] ? am : 8'd0;
                checks++;
                if (add_a8 !== aa || add_b8 !== eb) begin
                    errors++;
                    $display("FAIL %s adder ports cycle %0d: got a=%0d b=%0d want a=%0d b=%0d",
                             tag, k, add_a8, add_b8, aa, eb);
                end
                checks++;
                if (product8 !== prev8) begin
                    errors++;
                    $display("FAIL %s product held cycle %0d: got %0d want %0d", tag, k, product8, prev8);
                end
                s  = {1'b0, aa} + {1'b0, eb};
                aa = s[8:1];
                aq = {s[0], aq[7:1]};
            end else begin
                checks++;
                if (product8 !== expv) begin
                    errors++;
                    $display("FAIL %s product: got %0d want %0d", tag, product8, expv);
                end
            end
        end
        prev8 = expv;
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start64 = 1'b0;
        mc8 = '0; mp8 = '0; mc64 = '0; mp64 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0 ||
            add_a8 !== 8'd0 || add_b8 !== 8'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b product=%0d a=%0d b=%0d want all 0",
                     busy8, done8, product8, add_a8, add_b8);
        end
        checks++;
        if (busy64 !== 1'b0 || done64 !== 1'b0 || product64 !== 128'd0 ||
            add_a64 !== 64'd0 || add_b64 !== 64'd0) begin
            errors++;
            $display("FAIL reset64: got busy=%b done=%b product=%h a=%h b=%h want all 0",
                     busy64, done64, product64, add_a64, add_b64);
        end
        prev8 = '0;
    endtask

    task automatic test_basic();
        run8(8'd13, 8'd11, 16'd143, "13x11");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (product8 !== 16'd143 || busy8 !== 1'b0 || done8 !== 1'b0 ||
                add_a8 !== 8'd0 || add_b8 !== 8'd0) begin
                errors++;
                $display("FAIL idle hold %0d: got product=%0d busy=%b done=%b a=%0d b=%0d want 143 0 0 0 0",
                         k, product8, busy8, done8, add_a8, add_b8);
            end
        end
    endtask

    task automatic test_carry();
        run8(8'd255, 8'd255, 16'hFE01, "255x255");
    endtask

    task automatic test_zero();
        run8(8'd0, 8'd200, 16'd0, "0x200");
        run8(8'd200, 8'd0, 16'd0, "200x0");
    endtask

    task automatic test_wide();
        @(negedge clk);
        mc64 = '1; mp64 = '1; start64 = 1'b1;
        @(posedge clk);
        #1 start64 = 1'b0; mc64 = '0; mp64 = '0;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            checks++;
            if (done64 !== ((k == 65) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL wide done cycle %0d: got %b want %b", k, done64, (k == 65));
            end
            if (k == 65) begin
                checks++;
                if (product64 !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
                    errors++;
                    $display("FAIL wide product: got %h want fffffffffffffffe0000000000000001", product64);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mm, qq;
        logic [15:0] expv;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            mc8 = 8'(c * 7 + 3);
            mp8 = 8'(c * 13 + 5);
            start8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (done8 !== (((c % 10) == 8) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL b2b done after edge %0d: got %b want %b", c, done8, ((c % 10) == 8));
            end
            checks++;
            if (busy8 !== (((c % 10) == 9) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL b2b busy after edge %0d: got %b want %b", c, busy8, ((c % 10) != 9));
            end
            if ((c % 10) == 8) begin
                mm = 8'((c - 8) * 7 + 3);
                qq = 8'((c - 8) * 13 + 5);
                expv = {8'd0, mm} * {8'd0, qq};
                checks++;
                if (product8 !== expv) begin
                    errors++;
                    $display("FAIL b2b product after edge %0d: got %0d want %0d", c, product8, expv);
                end
                prev8 = expv;
            end
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        mc8 = 8'd100; mp8 = 8'd3; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0 ||
            add_a8 !== 8'd0 || add_b8 !== 8'd0) begin
            errors++;
            $display("FAIL mid reset: got busy=%b done=%b product=%0d a=%0d b=%0d want all 0",
                     busy8, done8, product8, add_a8, add_b8);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL after reset %0d: got done=%b busy=%b want 0 0", k, done8, busy8);
            end
        end
        prev8 = '0;
        run8(8'd7, 8'd6, 16'd42, "7x6");
    endtask

    task automatic test_sweep();
        int fm[16] = '{0, 1, 128, 255, 0, 255, 1, 128, 255, 1, 128, 0, 2, 127, 129, 254};
        int fq[16] = '{0, 255, 128, 1, 255, 0, 1, 255, 128, 128, 1, 128, 254, 129, 127, 2};
        logic [7:0] m, q;
        for (int i = 0; i < 2000; i++) begin
            if (i < 16) begin
                m = 8'(fm[i]);
                q = 8'(fq[i]);
            end else begin
                m = 8'($urandom_range(0, 255));
                q = 8'($urandom_range(0, 255));
            end
            run8(m, q, {8'd0, m} * {8'd0, q}, "sweep");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_wide();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
